fetch_controller: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 39 +++
 rtl/fetch_controller.sv | 142 ++++++++++++++
 tb/tb_fetch_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned IF_ADDR_W = 64;
    localparam int unsigned IF_INST_W = 32;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0063;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_INST_W-1:0] instr;
        logic                 valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; otherwise the entry holds.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [IF_INST_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t entry_q, entry_d;
    if_id_t bubble_entry;

    assign bubble_entry = '{pc: '0, instr: NOP_WORD, valid: 1'b0};

    always_comb begin
        entry_d = entry_q;
        if (bubble) begin
            entry_d = bubble_entry;
        end else if (load) begin
            entry_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= bubble_entry;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, feeds IF/ID, handles stall/redirect/halt/fault.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_controller #(
    parameter int unsigned        ADDR_W     = fetch_pkg::IF_ADDR_W,
    parameter int unsigned        INST_W     = fetch_pkg::IF_INST_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int unsigned        IMEM_BYTES = 132,
    parameter logic [INST_W-1:0]  NOP_INSTR  = fetch_pkg::NOP_INSTR,
    parameter logic [INST_W-1:0]  HALT_INSTR = fetch_pkg::HALT_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] Inst_Address,
    input  logic [INST_W-1:0] Instruction,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              resume,
    output logic [ADDR_W-1:0] IF_ID_PC,
    output logic [INST_W-1:0] IF_ID_Instruction,
    output logic              IF_ID_valid,
    output logic              halted,
    output logic              fetch_fault
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - 4);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_legal;
    logic              ifid_load, ifid_bubble;
    if_id_t            ifid_d, ifid_q;

    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = '{pc: pc_q, instr: Instruction, valid: 1'b1};
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_d        = branch_target;
                    ifid_bubble = 1'b1;
                end else if (!stall) begin
                    if (!pc_legal) begin
                        ifid_bubble = 1'b1;
                        state_d     = FAULT;
                    end else begin
                        ifid_load = 1'b1;
                        if (Instruction == HALT_INSTR) begin
                            state_d = HALT;
                        end else begin
                            pc_d = pc_q + ADDR_W'(4);
                        end
                    end
                end
            end
            HALT: begin
                // An older branch resolving taken still wins over the halt.
                if (branch_taken) begin
                    pc_d        = branch_target;
                    ifid_bubble = 1'b1;
                    state_d     = RUN;
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                    if (resume) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = RUN;
                    end
                end
            end
            default: ifid_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign Inst_Address      = pc_q;
    assign IF_ID_PC          = ifid_q.pc;
    assign IF_ID_Instruction = ifid_q.instr;
    assign IF_ID_valid       = ifid_q.valid;
    assign halted            = (state_q == HALT);
    assign fetch_fault       = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (ifid_load && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if ((state_q == RUN) && stall && !branch_taken && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, corner sequences, random vs model.
module tb_fetch_controller;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HLT  = 32'h0000_0063;
    localparam int          M_RUN = 0, M_HALT = 1, M_FAULT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        stall, branch_taken, resume;
    logic [63:0] branch_target;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_valid, halted, fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    logic [31:0] mem [0:63];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign Instruction = (Inst_Address < 64'd132) ? mem[Inst_Address[7:2]] : 32'hDEAD_BEEF;

    fetch_controller dut (
        .clk               (clk),
        .reset             (reset),
        .Inst_Address      (Inst_Address),
        .Instruction       (Instruction),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .resume            (resume),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_valid       (IF_ID_valid),
        .halted            (halted),
        .fetch_fault       (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
       ,.fetch_count       (fetch_count),
        .stall_count       (stall_count)
`endif
    );

    typedef struct {
        logic        st, br, rs;
        logic [63:0] tgt;
        logic [63:0] e_addr, e_pc;
        logic [31:0] e_ins;
        logic        e_v, e_h, e_f;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_ins;
    logic        m_v;
    int          m_mode;
    longint      m_fc, m_sc;

    function automatic vec_t mk(logic st, logic br, logic rs, logic [63:0] tgt,
                                logic [63:0] a, logic [63:0] p, logic [31:0] ins,
                                logic v, logic h, logic f);
        vec_t x;
        x.st = st; x.br = br; x.rs = rs; x.tgt = tgt;
        x.e_addr = a; x.e_pc = p; x.e_ins = ins; x.e_v = v; x.e_h = h; x.e_f = f;
        return x;
    endfunction

    function automatic logic [31:0] word_at(logic [63:0] a);
        return (a < 64'd132) ? mem[a[7:2]] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] a, input logic [63:0] p,
                             input logic [31:0] ins, input logic v, input logic h, input logic f);
        chk({tag, ".addr"},  Inst_Address, a);
        chk({tag, ".ifpc"},  IF_ID_PC, p);
        chk({tag, ".ifins"}, 64'(IF_ID_Instruction), 64'(ins));
        chk({tag, ".valid"}, 64'(IF_ID_valid), 64'(v));
        chk({tag, ".halt"},  64'(halted), 64'(h));
        chk({tag, ".fault"}, 64'(fetch_fault), 64'(f));
    endtask

    task automatic drive(input logic st, input logic br, input logic rs, input logic [63:0] tgt);
        stall = st; branch_taken = br; resume = rs; branch_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 64'h0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_ifpc = 64'h0; m_ins = NOP; m_v = 1'b0; m_mode = M_RUN;
        m_fc = 0; m_sc = 0;
    endtask

    task automatic model_bubble();
        m_ifpc = 64'h0; m_ins = NOP; m_v = 1'b0;
    endtask

    // Fetch-stage rules for one clock edge, taken from the current model state and inputs.
    task automatic model_step();
        logic [31:0] w;
        w = word_at(m_pc);
        if (m_mode == M_RUN && stall && !branch_taken) m_sc++;
        if (m_mode == M_FAULT) begin
            model_bubble();
        end else if (branch_taken) begin
            m_pc = branch_target;
            model_bubble();
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!stall) begin
                if ((m_pc % 4 != 0) || (m_pc > 64'd128)) begin
                    model_bubble();
                    m_mode = M_FAULT;
                end else begin
                    m_ifpc = m_pc; m_ins = w; m_v = 1'b1; m_fc++;
                    if (w == HLT) m_mode = M_HALT;
                    else m_pc = m_pc + 64'd4;
                end
            end
        end else if (!stall) begin
            model_bubble();
            if (resume) begin
                m_pc = m_pc + 64'd4;
                m_mode = M_RUN;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 64'h0);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_1093 | (32'(i) << 20);
        mem[0] = 32'h0030_0293;
        mem[1] = 32'h0053_3223;
        mem[8] = HLT;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset", 64'h0, 64'h0, NOP, 0, 0, 0);

        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h4,  64'h0,  32'h0030_0293, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h8,  64'h4,  32'h0053_3223, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  64'h8,  64'h4,  32'h0053_3223, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  64'h8,  64'h4,  32'h0053_3223, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'hC,  64'h8,  mem[2],        1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h30, 64'h30, 64'h0,  NOP,           0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h34, 64'h30, mem[12],       1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 64'h20, 64'h20, 64'h0,  NOP,           0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h20, 64'h20, HLT,           1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h20, 64'h0,  NOP,           0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  64'h20, 64'h0,  NOP,           0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 64'h0,  64'h20, 64'h0,  NOP,           0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 64'h0,  64'h24, 64'h0,  NOP,           0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h28, 64'h24, mem[9],        1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 64'h80, 64'h80, 64'h0,  NOP,           0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h84, 64'h80, mem[32],       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,  64'h84, 64'h0,  NOP,           0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 64'h0,  64'h84, 64'h0,  NOP,           0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].rs, vecs[i].tgt);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc,
                      vecs[i].e_ins, vecs[i].e_v, vecs[i].e_h, vecs[i].e_f);
        end

        // Illegal branch targets are accepted, then fault on the next edge; fault is sticky.
        for (int k = 0; k < 2; k++) begin
            logic [63:0] bad;
            bad = (k == 0) ? 64'h32 : 64'h84;
            pulse_reset();
            drive(0, 1, 0, bad);
            tick();
            check_all($sformatf("badtgt%0d.take", k), bad, 64'h0, NOP, 0, 0, 0);
            drive(0, 0, 0, 64'h0);
            tick();
            check_all($sformatf("badtgt%0d.fault", k), bad, 64'h0, NOP, 0, 0, 1);
            drive(0, 1, 0, 64'h0);
            tick();
            check_all($sformatf("badtgt%0d.ignored", k), bad, 64'h0, NOP, 0, 0, 1);
        end

        // Taken branch while halted redirects and leaves HALT.
        pulse_reset();
        drive(0, 1, 0, 64'h20);
        tick();
        drive(0, 0, 0, 64'h0);
        tick();
        check_all("haltbr.halt", 64'h20, 64'h20, HLT, 1, 1, 0);
        drive(1, 1, 0, 64'h10);
        tick();
        check_all("haltbr.redirect", 64'h10, 64'h0, NOP, 0, 0, 0);

        // Asynchronous reset between edges at PC 0x40.
        drive(0, 1, 0, 64'h40);
        tick();
        drive(0, 0, 0, 64'h0);
        tick();
        chk("areset.pre_addr", Inst_Address, 64'h44);
        #3;
        reset = 1'b1;
        #1;
        check_all("areset", 64'h0, 64'h0, NOP, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("areset.fcnt", 64'(fetch_count), 64'h0);
        chk("areset.scnt", 64'(stall_count), 64'h0);
`endif
        #1;
        reset = 1'b0;
        tick();

        // Random program and control inputs against the model.
        for (int i = 0; i < 33; i++) mem[i] = ($urandom_range(0, 6) == 0) ? HLT : ($urandom | 32'h1);
        pulse_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            int r;
            logic [63:0] tgt;
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
                model_reset();
            end
            r = $urandom_range(0, 9);
            if (r == 0)      tgt = {32'($urandom), 32'($urandom)};
            else if (r == 1) tgt = 64'd132 + 64'($urandom_range(0, 8));
            else if (r == 2) tgt = 64'(4 * $urandom_range(0, 32) + $urandom_range(1, 3));
            else             tgt = 64'(4 * $urandom_range(0, 32));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0, tgt);
            model_step();
            tick();
            check_all($sformatf("rnd%0d", c), m_pc, m_ifpc, m_ins, m_v,
                      m_mode == M_HALT, m_mode == M_FAULT);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rnd%0d.fcnt", c), 64'(fetch_count), 64'(m_fc));
            chk($sformatf("rnd%0d.scnt", c), 64'(stall_count), 64'(m_sc));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
